// File: rtl/leaky_relu_h_cache_pkg.sv
// Shared Q8.8 fixed-point definitions for the per-column training datapath
// (fxp_mul, leaky_relu stages, H caches).
package leaky_relu_h_cache_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;

  // Encoded as {wr_en, rd_en}
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_RD    = 2'b01,
    OP_WR    = 2'b10,
    OP_WR_RD = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/leaky_relu_h_cache_fifo_core.sv
// sync_fifo_core: reusable single-clock FIFO (storage, pointers, occupancy).
// Callers gate wr_en/rd_en; srst flushes pointers and count.
module sync_fifo_core
  import leaky_relu_h_cache_pkg::*;
#(
  parameter int   DATA_W = leaky_relu_h_cache_pkg::DATA_W,
  parameter int   DEPTH  = 16,
  localparam int  ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  fifo_op_e          op;

  assign op = fifo_op_e'({wr_en, rd_en});

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
      case (op)
        OP_WR:   count <= count + (ADDR_W+1)'(1);
        OP_RD:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by the
  // pointers, so stale words are never observed and the array maps to RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !srst) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/leaky_relu_h_cache.sv
// Per-column H cache: stores forward-pass pre-activations and replays them in
// FIFO order, registered and aligned with incoming backward-pass gradients.
module leaky_relu_h_cache
  import leaky_relu_h_cache_pkg::*;
#(
  parameter int  DATA_W = leaky_relu_h_cache_pkg::DATA_W,
  parameter int  DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              h_valid_in,
  input  logic [DATA_W-1:0] h_data_in,
  input  logic              grad_valid_in,
  input  logic [DATA_W-1:0] grad_data_in,
  output logic              lr_d_valid_out,
  output logic [DATA_W-1:0] lr_d_data_out,
  output logic [DATA_W-1:0] lr_d_H_data_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  logic              flush;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  assign flush = rst | clear;
  assign rd_en = grad_valid_in & ~empty;
  // A read in the same cycle frees a slot, so a full buffer still accepts H.
  assign wr_en = h_valid_in & (~full | rd_en);

  sync_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .srst    (flush),
    .wr_en   (wr_en),
    .wr_data (h_data_in),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Gradients with no stored H still go out valid with H = 0 (pass-through).
  always_ff @(posedge clk) begin
    if (flush) begin
      lr_d_valid_out  <= 1'b0;
      lr_d_data_out   <= '0;
      lr_d_H_data_out <= '0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      lr_d_valid_out  <= grad_valid_in;
      lr_d_data_out   <= grad_valid_in ? grad_data_in : '0;
      lr_d_H_data_out <= rd_en ? rd_data : '0;
      overflow        <= overflow | (h_valid_in & full & ~rd_en);
      underflow       <= underflow | (grad_valid_in & empty);
    end
  end

endmodule

// File: tb/tb_leaky_relu_h_cache.sv
// Self-checking bench for leaky_relu_h_cache: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_leaky_relu_h_cache;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst, clear, h_valid_in, grad_valid_in;
  logic [DW-1:0] h_data_in, grad_data_in;
  logic          lr_d_valid_out;
  logic [DW-1:0] lr_d_data_out, lr_d_H_data_out;
  logic [AW:0]   count;
  logic          full, empty, overflow, underflow;

  leaky_relu_h_cache #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .h_valid_in      (h_valid_in),
    .h_data_in       (h_data_in),
    .grad_valid_in   (grad_valid_in),
    .grad_data_in    (grad_data_in),
    .lr_d_valid_out  (lr_d_valid_out),
    .lr_d_data_out   (lr_d_data_out),
    .lr_d_H_data_out (lr_d_H_data_out),
    .count           (count),
    .full            (full),
    .empty           (empty),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: a queue of stored H values and the expected output regs.
  logic [DW-1:0] q[$];
  logic          m_valid, m_ovf, m_unf, model_on;
  logic [DW-1:0] m_data, m_h;

  task automatic model_step();
    int  n;
    bit  rd, wr;
    if (rst || clear) begin
      q.delete();
      m_valid = 0; m_data = 0; m_h = 0; m_ovf = 0; m_unf = 0;
    end else begin
      n  = q.size();
      rd = grad_valid_in && n > 0;
      wr = h_valid_in && (n < DEPTH || rd);
      m_valid = grad_valid_in;
      m_data  = grad_valid_in ? grad_data_in : '0;
      m_h     = rd ? q.pop_front() : '0;
      if (wr) q.push_back(h_data_in);
      if (h_valid_in && n == DEPTH && !rd) m_ovf = 1;
      if (grad_valid_in && n == 0) m_unf = 1;
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      check("valid",     32'(lr_d_valid_out),  32'(m_valid));
      check("grad",      32'(lr_d_data_out),   32'(m_data));
      check("h",         32'(lr_d_H_data_out), 32'(m_h));
      check("count",     32'(count),           32'(q.size()));
      check("full",      32'(full),            32'(q.size() == DEPTH));
      check("empty",     32'(empty),           32'(q.size() == 0));
      check("overflow",  32'(overflow),        32'(m_ovf));
      check("underflow", 32'(underflow),       32'(m_unf));
    end
  end

  task automatic cycle(input logic hv, input logic [DW-1:0] hd,
                       input logic gv, input logic [DW-1:0] gd,
                       input logic c = 1'b0, input logic r = 1'b0);
    h_valid_in = hv; h_data_in = hd; grad_valid_in = gv; grad_data_in = gd;
    clear = c; rst = r;
    @(posedge clk);
    model_step();
    model_on = 1'b1;
    @(negedge clk);
    h_valid_in = 0; grad_valid_in = 0; clear = 0; rst = 0;
  endtask

  logic [DW-1:0] t1_h [3];

  initial begin
    model_on = 0;
    rst = 1; clear = 0; h_valid_in = 0; grad_valid_in = 0;
    h_data_in = 0; grad_data_in = 0;
    @(negedge clk);
    cycle(0, 0, 0, 0, 0, 1);
    check("reset_count", 32'(count), 0);
    check("reset_empty", 32'(empty), 1);
    check("reset_valid", 32'(lr_d_valid_out), 0);

    // 1: three H, then three gradients
    t1_h[0] = 16'h0100; t1_h[1] = 16'hFF00; t1_h[2] = 16'h0080;
    for (int i = 0; i < 3; i++) cycle(1, t1_h[i], 0, 0);
    check("t1_count3", 32'(count), 3);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 16'h0200);
      check("t1_valid", 32'(lr_d_valid_out), 1);
      check("t1_h", 32'(lr_d_H_data_out), 32'(t1_h[i]));
      check("t1_grad", 32'(lr_d_data_out), 32'h0200);
    end
    check("t1_count0", 32'(count), 0);

    // 2: DEPTH+1 writes, no reads
    for (int i = 0; i <= DEPTH; i++) cycle(1, 16'(16'h1000 + i), 0, 0);
    check("t2_full", 32'(full), 1);
    check("t2_overflow", 32'(overflow), 1);
    check("t2_count", 32'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 0, 1, 0);
      check("t2_h", 32'(lr_d_H_data_out), 32'(16'h1000 + i));
    end
    check("t2_empty", 32'(empty), 1);
    cycle(0, 0, 0, 0, 1);

    // 3: full buffer, simultaneous write and read
    for (int i = 0; i < DEPTH; i++) cycle(1, 16'(16'h2000 + i), 0, 0);
    cycle(1, 16'h2FFF, 1, 16'h0001);
    check("t3_count", 32'(count), DEPTH);
    check("t3_overflow", 32'(overflow), 0);
    check("t3_h", 32'(lr_d_H_data_out), 32'h2000);
    cycle(0, 0, 0, 0, 1);

    // 4: gradient on empty buffer
    cycle(0, 0, 1, 16'hFE00);
    check("t4_valid", 32'(lr_d_valid_out), 1);
    check("t4_grad", 32'(lr_d_data_out), 32'hFE00);
    check("t4_h", 32'(lr_d_H_data_out), 0);
    check("t4_underflow", 32'(underflow), 1);
    // empty with write+read: no bypass, write lands
    cycle(1, 16'h0AAA, 1, 16'h0011);
    check("t4_nobypass_h", 32'(lr_d_H_data_out), 0);
    check("t4_nobypass_count", 32'(count), 1);

    // 5: clear with gradient present drops everything
    for (int i = 0; i < 5; i++) cycle(1, 16'(16'h4000 + i), 0, 0);
    cycle(1, 16'h4444, 1, 16'h0123, 1);
    check("t5_valid", 32'(lr_d_valid_out), 0);
    check("t5_grad", 32'(lr_d_data_out), 0);
    check("t5_h", 32'(lr_d_H_data_out), 0);
    check("t5_count", 32'(count), 0);
    check("t5_flags", 32'({overflow, underflow}), 0);

    // 6: rst mid-stream with count = 3 and valid out high
    for (int i = 0; i < 4; i++) cycle(1, 16'(16'h3000 + i), 0, 0);
    cycle(0, 0, 1, 16'h0055);
    check("t6_pre_count", 32'(count), 3);
    check("t6_pre_valid", 32'(lr_d_valid_out), 1);
    cycle(1, 16'h3333, 1, 16'h0066, 0, 1);
    check("t6_valid", 32'(lr_d_valid_out), 0);
    check("t6_h", 32'(lr_d_H_data_out), 0);
    check("t6_count", 32'(count), 0);

    // wrap: 3*DEPTH write/read pairs
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cycle(1, 16'(16'h5000 + 3 * i), 0, 0);
      cycle(0, 0, 1, 16'(i));
      check("wrap_h", 32'(lr_d_H_data_out), 32'(16'h5000 + 3 * i));
    end
    check("wrap_empty", 32'(empty), 1);

    model_on = 0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
